// File: rtl/seg7_scan_decoder.sv
// Reads a frame of active-low 7-segment patterns (LSD first) back into hex nibbles,
// flagging illegal patterns and aborting frames that stall longer than TIMEOUT cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start; results of the last frame are held
// COLLECT | In_Ready high, accepting one digit per In_Valid handshake
// DONE    | one-cycle Done pulse, Error/Timed_Out settled
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic                    Clk,
    input  logic                    R,
    input  logic                    Start,
    input  logic [0:6]              Seg,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic [4*NUM_DIGITS-1:0] Value,
    output logic [NUM_DIGITS-1:0]   Bad_Mask,
    output logic                    Error,
    output logic                    Timed_Out,
    output logic                    Busy,
    output logic                    Done
);

    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] K_LAST    = KW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [KW-1:0]           digit_idx, digit_idx_nxt;
    logic [IW-1:0]           idle_cnt, idle_cnt_nxt;
    logic [4*NUM_DIGITS-1:0] value_nxt;
    logic [NUM_DIGITS-1:0]   bad_nxt;
    logic                    error_nxt, timed_out_nxt;
    logic [4:0]              dec;

    // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
    function automatic logic [4:0] decode(input logic [0:6] pat);
        case (pat)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0001100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        state_nxt     = state;
        digit_idx_nxt = digit_idx;
        idle_cnt_nxt  = idle_cnt;
        value_nxt     = Value;
        bad_nxt       = Bad_Mask;
        error_nxt     = Error;
        timed_out_nxt = Timed_Out;
        dec           = decode(Seg);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt     = S_COLLECT;
                    digit_idx_nxt = '0;
                    idle_cnt_nxt  = '0;
                    value_nxt     = '0;
                    bad_nxt       = '0;
                    error_nxt     = 1'b0;
                    timed_out_nxt = 1'b0;
                end
            end
            S_COLLECT: begin
                if (In_Valid) begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (KW'(d) == digit_idx) begin
                            value_nxt[4*d +: 4] = dec[3:0];
                            bad_nxt[d]          = dec[4];
                        end
                    end
                    idle_cnt_nxt = '0;
                    if (digit_idx == K_LAST) begin
                        state_nxt = S_DONE;
                        error_nxt = |bad_nxt;
                    end else begin
                        digit_idx_nxt = digit_idx + 1'b1;
                    end
                end else begin
                    // Saturating; the frame leaves COLLECT as the count reaches TIMEOUT.
                    if (idle_cnt != IW'(TIMEOUT)) idle_cnt_nxt = idle_cnt + 1'b1;
                    if (idle_cnt >= IDLE_LAST) begin
                        state_nxt     = S_DONE;
                        timed_out_nxt = 1'b1;
                        error_nxt     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state     <= S_IDLE;
            digit_idx <= '0;
            idle_cnt  <= '0;
            Value     <= '0;
            Bad_Mask  <= '0;
            Error     <= 1'b0;
            Timed_Out <= 1'b0;
        end else begin
            state     <= state_nxt;
            digit_idx <= digit_idx_nxt;
            idle_cnt  <= idle_cnt_nxt;
            Value     <= value_nxt;
            Bad_Mask  <= bad_nxt;
            Error     <= error_nxt;
            Timed_Out <= timed_out_nxt;
        end
    end

    assign In_Ready = (state == S_COLLECT);
    assign Busy     = (state != S_IDLE);
    assign Done     = (state == S_DONE);

endmodule
